// File: rtl/cls_pkg.sv
// Shared classification-datapath package: default table geometry and the
// index-width helper used by the key extractor, the TCAM LUT and the action stage.
package cls_pkg;

    localparam int KEY_W_DEF     = 36;
    localparam int NUM_RULES_DEF = 64;
    localparam int CNT_W_DEF     = 32;

    // Smallest r with 2**r >= n; used to size rule indices.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/lut_prio_enc.sv
// Lowest-index priority encoder: reports whether any match bit is set and the
// index of the lowest one (index 0 when nothing matched).
module lut_prio_enc #(
    parameter int NUM_RULES = 64,
    parameter int IDX_W     = 6
) (
    input  logic [NUM_RULES-1:0] match_i,
    output logic                 hit_o,
    output logic [IDX_W-1:0]     idx_o
);

    // Scan from the top down so the last assignment wins with the lowest set index.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = NUM_RULES - 1; i >= 0; i--) begin
            if (match_i[i]) begin
                hit_o = 1'b1;
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/tcam_lut_classifier.sv
// Ternary (value/mask) rule table with runtime update port and a two-stage
// lookup pipeline (match vector, then priority encode) under valid/ready
// backpressure. Lowest matching rule index wins.
module tcam_lut_classifier
    import cls_pkg::*;
#(
    parameter  int KEY_W     = KEY_W_DEF,
    parameter  int NUM_RULES = NUM_RULES_DEF,
    parameter  int CNT_W     = CNT_W_DEF,
    localparam int IDX_W     = clog2(NUM_RULES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [KEY_W-1:0] in_key,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_hit,
    output logic [IDX_W-1:0] out_idx,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic [KEY_W-1:0] upd_value,
    input  logic [KEY_W-1:0] upd_mask,
    input  logic             upd_en,
    output logic [CNT_W-1:0] lookup_cnt,
    output logic [CNT_W-1:0] hit_cnt
);

    logic [NUM_RULES-1:0] match_d;
    logic [NUM_RULES-1:0] match_q;
    logic                 s1_valid_q;
    logic                 out_valid_q;
    logic                 out_hit_q;
    logic [IDX_W-1:0]     out_idx_q;
    logic [CNT_W-1:0]     lookup_cnt_q;
    logic [CNT_W-1:0]     hit_cnt_q;
    logic                 enc_hit;
    logic [IDX_W-1:0]     enc_idx;
    logic                 stall;
    logic                 accept;

    // A full S2 that downstream refuses freezes the whole pipe.
    assign stall    = out_valid_q && !out_ready;
    assign in_ready = !stall && !reset;
    assign accept   = in_valid && in_ready;

    // One storage slot per rule. Each slot decodes its own write strobe, so an
    // update index beyond the table (non-power-of-2 sizes) simply hits no slot.
    // The match bit is formed from the current contents, so a lookup accepted
    // on the same edge as a write still sees the old rule.
    generate
        for (genvar gi = 0; gi < NUM_RULES; gi++) begin : g_rule
            logic [KEY_W-1:0] value_q;
            logic [KEY_W-1:0] mask_q;
            logic             en_q;
            logic             wr;

            assign wr = upd_valid && !reset && (upd_idx == IDX_W'(gi));

            // Enable bit is the only per-rule state that needs clearing on reset.
            always_ff @(posedge clk) begin
                if (reset) begin
                    en_q <= 1'b0;
                end else if (wr) begin
                    en_q <= upd_en;
                end
            end

            // Value/mask payload; contents are irrelevant while the rule is disabled.
            always_ff @(posedge clk) begin
                if (wr) begin
                    value_q <= upd_value;
                    mask_q  <= upd_mask;
                end
            end

            assign match_d[gi] = en_q && (((in_key ^ value_q) & mask_q) == '0);
        end
    endgenerate

    lut_prio_enc #(
        .NUM_RULES (NUM_RULES),
        .IDX_W     (IDX_W)
    ) u_prio_enc (
        .match_i (match_q),
        .hit_o   (enc_hit),
        .idx_o   (enc_idx)
    );

    // Two-stage lookup pipeline; both stages advance together unless stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            match_q     <= '0;
            out_valid_q <= 1'b0;
            out_hit_q   <= 1'b0;
            out_idx_q   <= '0;
        end else if (!stall) begin
            s1_valid_q  <= accept;
            match_q     <= match_d;
            out_valid_q <= s1_valid_q;
            out_hit_q   <= s1_valid_q && enc_hit;
            out_idx_q   <= s1_valid_q ? enc_idx : '0;
        end
    end

    // Statistics: accepted lookups and delivered hits, wrapping naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            lookup_cnt_q <= '0;
            hit_cnt_q    <= '0;
        end else begin
            if (accept) begin
                lookup_cnt_q <= lookup_cnt_q + 1'b1;
            end
            if (out_valid_q && out_ready && out_hit_q) begin
                hit_cnt_q <= hit_cnt_q + 1'b1;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_hit    = out_hit_q;
    assign out_idx    = out_idx_q;
    assign lookup_cnt = lookup_cnt_q;
    assign hit_cnt    = hit_cnt_q;

endmodule
